// File: rtl/window_arbiter_pkg.sv
// Shared types and constants for the window arbiter: FSM encoding and window timer sizing.
package window_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int WINDOW_MAX = 32;
  localparam int TIMER_W    = 5;

endpackage

// File: rtl/window_arbiter_if.sv
// Request/grant bundle between requesters (master) and the window arbiter (slave).
interface window_arbiter_if
  import window_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   release_pulse;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic [TIMER_W-1:0] slot_count;
  logic               expired;

  modport master (
    output req, release_pulse,
    input  grant, grant_id, busy, slot_count, expired
  );

  modport slave (
    input  req, release_pulse,
    output grant, grant_id, busy, slot_count, expired
  );
endinterface

// File: rtl/window_arbiter_window_timer.sv
// Saturating grant-window timer: synchronous clear has priority over enable; reached flags WINDOW-1.
module window_timer
  import window_arbiter_pkg::*;
#(
  parameter int WINDOW = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [TIMER_W-1:0] count,
  output logic               reached
);
  localparam int WIN_EFF = (WINDOW > WINDOW_MAX) ? WINDOW_MAX : WINDOW;

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign reached = (count_q == TIMER_W'(WIN_EFF - 1));
endmodule

// File: rtl/window_arbiter.sv
// Round-robin time-slot arbiter: one owner at a time, grant capped by a window timer, one GAP cycle between owners.
module window_arbiter
  import window_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WINDOW = 32
) (
  input  logic             clk,
  input  logic             reset,
  window_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic               expired_q, expired_d;

  logic               tmr_clr, tmr_en, tmr_reached;
  logic [TIMER_W-1:0] tmr_count;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    idx;
  logic               owner_done;

  window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .count   (tmr_count),
    .reached (tmr_reached)
  );

  // Search upward from the requester after the last winner, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(last_id_q) + i) % N_REQ);
      if (!pick_found && bus.req[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    expired_d  = 1'b0;
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;
    owner_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          grant_d    = N_REQ'(1) << pick_id;
          grant_id_d = pick_id;
          last_id_d  = pick_id;
        end
      end
      GRANT: begin
        tmr_clr    = 1'b0;
        tmr_en     = 1'b1;
        // An owner giving up the slot wins over a coincident terminal count.
        owner_done = bus.release_pulse[grant_id_q] || !bus.req[grant_id_q];
        if (owner_done || tmr_reached) begin
          state_d    = GAP;
          grant_d    = '0;
          grant_id_d = '0;
          expired_d  = !owner_done;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(N_REQ - 1);
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      expired_q  <= expired_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = |grant_q;
  assign bus.slot_count = (state_q == GRANT) ? tmr_count : '0;
  assign bus.expired    = expired_q;
endmodule

// File: tb/tb_window_arbiter.sv
// Bench for window_arbiter: WINDOW=32 and WINDOW=1 instances checked every cycle against a behavioural model.
module tb_window_arbiter;
  import window_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  window_arbiter_if #(.N_REQ(N)) bus0 ();
  window_arbiter_if #(.N_REQ(N)) bus1 ();

  window_arbiter #(.N_REQ(N), .WINDOW(32)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  window_arbiter #(.N_REQ(N), .WINDOW(1))  dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Behavioural model: owner (-1 when none), cycles owned so far, gap pending, expiry flag, last winner.
  int m_owner [2];
  int m_age   [2];
  int m_last  [2];
  bit m_gap   [2];
  bit m_exp   [2];
  int m_win   [2] = '{32, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, obs, exp, cyc, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_age[d]   = 0;
      m_last[d]  = N - 1;
      m_gap[d]   = 1'b0;
      m_exp[d]   = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] r, input logic [3:0] rl);
    int o;
    m_exp[d] = 1'b0;
    if (m_owner[d] >= 0) begin
      o = m_owner[d];
      if (rl[o] || !r[o]) begin
        m_owner[d] = -1;
        m_gap[d]   = 1'b1;
      end else if (m_age[d] == m_win[d] - 1) begin
        m_owner[d] = -1;
        m_gap[d]   = 1'b1;
        m_exp[d]   = 1'b1;
      end else begin
        m_age[d]++;
      end
    end else if (m_gap[d]) begin
      m_gap[d] = 1'b0;
    end else if (r != 4'b0) begin
      for (int i = 1; i <= N; i++) begin
        o = (m_last[d] + i) % N;
        if (r[o]) begin
          m_owner[d] = o;
          m_age[d]   = 0;
          m_last[d]  = o;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs(input int d);
    logic [3:0] g;
    logic [1:0] gid;
    logic       b, e;
    logic [4:0] sc;
    logic [3:0] eg;
    if (d == 0) begin
      g = bus0.grant; gid = bus0.grant_id; b = bus0.busy; sc = bus0.slot_count; e = bus0.expired;
    end else begin
      g = bus1.grant; gid = bus1.grant_id; b = bus1.busy; sc = bus1.slot_count; e = bus1.expired;
    end
    eg = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
    check($sformatf("d%0d grant", d),      32'(g),   32'(eg));
    check($sformatf("d%0d grant_id", d),   32'(gid), (m_owner[d] >= 0) ? m_owner[d] : 0);
    check($sformatf("d%0d busy", d),       32'(b),   32'(m_owner[d] >= 0));
    check($sformatf("d%0d slot_count", d), 32'(sc),  (m_owner[d] >= 0) ? m_age[d] : 0);
    check($sformatf("d%0d expired", d),    32'(e),   32'(m_exp[d]));
  endtask

  // Called at a negedge: drive, let one rising edge pass, then compare at the next negedge.
  task automatic step(input logic [3:0] r0, input logic [3:0] rl0,
                      input logic [3:0] r1, input logic [3:0] rl1);
    bus0.req = r0; bus0.release_pulse = rl0;
    bus1.req = r1; bus1.release_pulse = rl1;
    @(posedge clk);
    model_step(0, r0, rl0);
    model_step(1, r1, rl1);
    @(negedge clk);
    cyc++;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus0.req = '0; bus0.release_pulse = '0;
    bus1.req = '0; bus1.release_pulse = '0;
    #1;
    model_reset();
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int first_exp, regrant, pulses, busy_cnt, exp_seen, o;
    bit reached, done;
    logic [3:0] r0, rl0, r1, rl1;
    int order[$];

    bus0.req = '0; bus0.release_pulse = '0;
    bus1.req = '0; bus1.release_pulse = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs(0);
    check_outputs(1);
    reset = 1'b0;
    cyc = 0;

    // Single requester held: full window expiry, then regrant; WINDOW=1 instance repeats every 3 cycles.
    first_exp = -1; regrant = -1; pulses = 0;
    for (int k = 0; k < 36; k++) begin
      step(4'b0001, 4'b0, 4'b0010, 4'b0);
      if (bus0.expired && first_exp < 0) first_exp = cyc;
      if (cyc > 33 && bus0.grant[0] && regrant < 0) regrant = cyc;
      if (bus1.expired) pulses++;
    end
    check("s1 expiry cycle", 32'(first_exp), 32'd33);
    check("s1 regrant cycle", 32'(regrant), 32'd35);
    check("s6 expired pulses", 32'(pulses), 32'd12);
    repeat (3) step(4'b0, 4'b0, 4'b0, 4'b0);

    // All requesting, each owner releases at slot_count 2.
    do_reset();
    busy_cnt = 0; exp_seen = 0;
    for (int k = 0; k < 24; k++) begin
      rl0 = (m_owner[0] >= 0 && m_age[0] == 2) ? (4'b0001 << m_owner[0]) : 4'b0;
      step(4'b1111, rl0, 4'b0, 4'b0);
      if (bus0.busy) busy_cnt++;
      if (bus0.expired) exp_seen++;
      if (bus0.busy && bus0.slot_count == 5'd0) order.push_back(int'(bus0.grant_id));
    end
    check("s2 grants", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5 && k < order.size(); k++)
      check($sformatf("s2 order[%0d]", k), 32'(order[k]), 32'(k % 4));
    check("s2 busy cycles", 32'(busy_cnt), 32'd15);
    check("s2 expired", 32'(exp_seen), 32'd0);
    repeat (3) step(4'b0, 4'b0, 4'b0, 4'b0);

    // Owner 2 releases at slot 5; requester 1 pulses release at slot 3 and is ignored.
    busy_cnt = 0; exp_seen = 0; done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rl0 = 4'b0;
      if (m_owner[0] == 2 && m_age[0] == 3) rl0 = 4'b0010;
      if (m_owner[0] == 2 && m_age[0] == 5) rl0 = 4'b0100;
      r0 = done ? 4'b0 : 4'b0100;
      if (rl0 == 4'b0100) done = 1'b1;
      step(r0, rl0, 4'b0, 4'b0);
      if (bus0.busy) busy_cnt++;
      if (bus0.expired) exp_seen++;
    end
    check("s3 busy cycles", 32'(busy_cnt), 32'd6);
    check("s3 expired", 32'(exp_seen), 32'd0);

    // Requester 3 drops req at the same edge slot_count reaches 31.
    busy_cnt = 0; exp_seen = 0; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_owner[0] == 3 && m_age[0] == 31) done = 1'b1;
      step(done ? 4'b0 : 4'b1000, 4'b0, 4'b0, 4'b0);
      if (bus0.busy) busy_cnt++;
      if (bus0.expired) exp_seen++;
    end
    check("s4 busy cycles", 32'(busy_cnt), 32'd32);
    check("s4 expired", 32'(exp_seen), 32'd0);

    // Reset in the middle of owner 1's grant, then 0 must win first.
    reached = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_owner[0] == 1 && m_age[0] == 10) begin
        reached = 1'b1;
        break;
      end
      step(4'b0010, 4'b0, 4'b0, 4'b0);
    end
    check("s5 reached slot 10", 32'(reached), 32'd1);
    do_reset();
    step(4'b0011, 4'b0, 4'b0, 4'b0);
    check("s5 first grant", 32'(bus0.grant), 32'd1);
    repeat (3) step(4'b0, 4'b0, 4'b0, 4'b0);

    // Randomised traffic with sparse releases and the occasional asynchronous reset.
    r0 = 4'b0; r1 = 4'b0;
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r0[b] = ~r0[b];
        if ($urandom_range(0, 5) == 0) r1[b] = ~r1[b];
      end
      rl0 = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      rl1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      o = int'($urandom_range(0, 299));
      if (o == 0) begin
        do_reset();
        r0 = 4'b0; r1 = 4'b0;
      end else begin
        step(r0, rl0, r1, rl1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
